// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter and its helpers:
// RV64I load/store func3 codes, FSM and owner encodings, and the hold-register layout.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

    // Everything the BUSY cycle needs to finish the access without the requester.
    typedef struct packed {
        owner_e      owner;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  func3;
        logic        err;
    } hold_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester-side data-memory port: request fields from the requester,
// grant/completion/result back from the arbiter.
interface dmem_port_arbiter_if;

    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  func3;
    logic        gnt;
    logic        done;
    logic        err;
    logic [63:0] rdata;

    modport master (
        output req, we, addr, wdata, func3,
        input  gnt, done, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata, func3,
        output gnt, done, err, rdata
    );

endinterface

// File: rtl/dmem_align_check.sv
// Flags RV64I loads/stores that are illegal (bad func3) or not naturally aligned.
// Purely combinational so any memory-side block can reuse it.
module dmem_align_check
    import dmem_pkg::*;
(
    input  logic       we_i,
    input  logic [2:0] func3_i,
    input  logic [2:0] addr_i,
    output logic       err_o
);

    logic illegal;
    logic misaligned;

    // Stores only have signed-size encodings; 3'b111 is never a valid access.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;

        if (func3_i == 3'b111) begin
            illegal = 1'b1;
        end else if (we_i && (func3_i == F3_BU || func3_i == F3_HU || func3_i == F3_WU)) begin
            illegal = 1'b1;
        end

        case (func3_i)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = addr_i[0];
            F3_W, F3_WU: misaligned = (addr_i[1:0] != 2'b00);
            F3_D:        misaligned = (addr_i != 3'b000);
            default:     misaligned = 1'b0;
        endcase

        err_o = illegal | misaligned;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester front end for dmem_top: CPU-priority arbitration with DMA
// anti-starvation, alignment rejection and the grant/BUSY two-cycle access sequence.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave cpu,
    dmem_port_arbiter_if.slave dma,
    output logic               mem_we,
    output logic               mem_re,
    output logic [63:0]        mem_addr,
    output logic [63:0]        mem_wdata,
    output logic [2:0]         mem_func3,
    input  logic [63:0]        mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    hold_t       hold_q, hold_d;
    logic [63:0] cpu_rdata_q, cpu_rdata_d;
    logic [63:0] dma_rdata_q, dma_rdata_d;

    logic        cpu_gnt, dma_gnt, grant, busy, dma_force;
    logic        g_we, g_err;
    logic [63:0] g_addr, g_wdata;
    logic [2:0]  g_func3;
    logic        held_load_ok;

    // DMA wins only when the CPU is idle or the CPU has used up its starve allowance.
    always_comb begin
        busy      = (state_q == BUSY) && !rst;
        dma_force = dma.req && (starve_q == STARVE_LIM);
        cpu_gnt   = (state_q == IDLE) && !rst && cpu.req && !dma_force;
        dma_gnt   = (state_q == IDLE) && !rst && dma.req && (!cpu.req || dma_force);
        grant     = cpu_gnt | dma_gnt;

        g_we      = cpu.we;
        g_addr    = cpu.addr;
        g_wdata   = cpu.wdata;
        g_func3   = cpu.func3;
        if (dma_gnt) begin
            g_we    = dma.we;
            g_addr  = dma.addr;
            g_wdata = dma.wdata;
            g_func3 = dma.func3;
        end
    end

    dmem_align_check u_align_check (
        .we_i    (g_we),
        .func3_i (g_func3),
        .addr_i  (g_addr[2:0]),
        .err_o   (g_err)
    );

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        hold_d       = hold_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        held_load_ok = !hold_q.we && !hold_q.err;

        mem_we    = grant && g_we && !g_err;
        mem_re    = busy && held_load_ok;
        mem_addr  = hold_q.addr;
        mem_wdata = hold_q.wdata;
        mem_func3 = hold_q.func3;

        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_func3 = '0;
        end else if (grant) begin
            mem_addr  = g_addr;
            mem_wdata = g_wdata;
            mem_func3 = g_func3;
        end

        case (state_q)
            IDLE: begin
                if (grant) begin
                    hold_d.owner = dma_gnt ? OWNER_DMA : OWNER_CPU;
                    hold_d.we    = g_we;
                    hold_d.addr  = g_addr;
                    hold_d.wdata = g_wdata;
                    hold_d.func3 = g_func3;
                    hold_d.err   = g_err;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                state_d = IDLE;
                if (held_load_ok && hold_q.owner == OWNER_CPU) begin
                    cpu_rdata_d = mem_rdata;
                end
                if (held_load_ok && hold_q.owner == OWNER_DMA) begin
                    dma_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts CPU wins against a waiting DMA; any DMA idle cycle forgives the debt.
        if (!dma.req || dma_gnt) begin
            starve_d = '0;
        end else if (cpu_gnt && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            hold_q      <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            hold_q      <= hold_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu.gnt   = cpu_gnt;
    assign dma.gnt   = dma_gnt;
    assign cpu.done  = busy && (hold_q.owner == OWNER_CPU);
    assign dma.done  = busy && (hold_q.owner == OWNER_DMA);
    assign cpu.err   = busy && (hold_q.owner == OWNER_CPU) && hold_q.err;
    assign dma.err   = busy && (hold_q.owner == OWNER_DMA) && hold_q.err;
    assign cpu.rdata = cpu_rdata_q;
    assign dma.rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a small byte-addressed memory
// standing in for dmem_top (aligned writes, sign/zero-extended reads).
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we, mem_re;
    logic [63:0] mem_addr, mem_wdata, memRdata;
    logic [2:0]  mem_func3;

    dmem_port_arbiter_if cpuIf();
    dmem_port_arbiter_if dmaIf();

    dmem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpuIf),
        .dma       (dmaIf),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_func3 (mem_func3),
        .mem_rdata (memRdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic        err;
        logic [63:0] rdata;
    } sbEntry_t;

    sbEntry_t    cpuQ[$];
    sbEntry_t    dmaQ[$];
    bit          pend[2];
    logic [63:0] pendVal[2];
    int          testsRun = 0;
    int          failCount = 0;
    int          bothGnt = 0;
    int          bothDone = 0;
    int          cycleCount = 0;
    bit          logGrants = 0;
    bit          gntLog[$];
    int          gntCycle[$];
    logic [63:0] memArr [0:31];

    // Memory model: writes land at the clock edge, reads are visible while mem_re is high.
    function automatic logic [63:0] loadExtract(input logic [63:0] dword,
                                                input logic [2:0] off,
                                                input logic [2:0] f3);
        logic [63:0] s;
        s = dword >> (32'(off) * 8);
        case (f3)
            F3_B:    return {{56{s[7]}}, s[7:0]};
            F3_H:    return {{48{s[15]}}, s[15:0]};
            F3_W:    return {{32{s[31]}}, s[31:0]};
            F3_BU:   return {56'd0, s[7:0]};
            F3_HU:   return {48'd0, s[15:0]};
            F3_WU:   return {32'd0, s[31:0]};
            default: return s;
        endcase
    endfunction

    assign memRdata = mem_re ? loadExtract(memArr[mem_addr[7:3]], mem_addr[2:0], mem_func3) : 64'd0;

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (mem_we) begin
            for (int b = 0; b < (1 << mem_func3[1:0]); b++) begin
                memArr[mem_addr[7:3]][(32'(mem_addr[2:0]) + b) * 8 +: 8] <= mem_wdata[b * 8 +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic monitorPort(input bit own, input logic gnt, input logic done,
                               input logic err, input logic [63:0] rdata);
        sbEntry_t e;
        string    name;
        bit       haveEntry;
        name      = own ? "dma" : "cpu";
        haveEntry = own ? (dmaQ.size() > 0) : (cpuQ.size() > 0);
        if (pend[own]) begin
            checkOutput({name, "Rdata"}, rdata, pendVal[own]);
            pend[own] = 0;
        end
        if (gnt) begin
            checkOutput({name, "MemReAtGnt"}, 64'(mem_re), 64'd0);
            if (haveEntry) begin
                e = own ? dmaQ[0] : cpuQ[0];
                checkOutput({name, "MemWeAtGnt"}, 64'(mem_we), 64'(e.we && !e.err));
                checkOutput({name, "MemAddrAtGnt"}, mem_addr, e.addr);
            end
        end
        if (done) begin
            if (!haveEntry) begin
                checkOutput({name, "UnexpectedDone"}, 64'd1, 64'd0);
            end else begin
                if (own) e = dmaQ.pop_front();
                else     e = cpuQ.pop_front();
                checkOutput({name, "Err"}, 64'(err), 64'(e.err));
                checkOutput({name, "MemReBusy"}, 64'(mem_re), 64'(!e.we && !e.err));
                checkOutput({name, "MemWeBusy"}, 64'(mem_we), 64'd0);
                checkOutput({name, "MemAddrBusy"}, mem_addr, e.addr);
                pend[own]    = 1;
                pendVal[own] = (!e.we && !e.err) ? e.rdata : rdata;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cpuIf.gnt && dmaIf.gnt) bothGnt++;
        if (cpuIf.done && dmaIf.done) bothDone++;
        if (logGrants && (cpuIf.gnt || dmaIf.gnt)) begin
            gntLog.push_back(dmaIf.gnt);
            gntCycle.push_back(cycleCount);
        end
        monitorPort(0, cpuIf.gnt, cpuIf.done, cpuIf.err, cpuIf.rdata);
        monitorPort(1, dmaIf.gnt, dmaIf.done, dmaIf.err, dmaIf.rdata);
    end

    // Called just after a rising edge; returns just after the edge that ends the grant cycle.
    task automatic applyStimulus(input bit own, input logic we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [2:0] f3,
                                 input logic expErr, input logic [63:0] expRdata,
                                 output int waited);
        sbEntry_t e;
        logic     g;
        e.we = we; e.addr = addr; e.err = expErr; e.rdata = expRdata;
        if (own) begin
            dmaQ.push_back(e);
            dmaIf.we = we; dmaIf.addr = addr; dmaIf.wdata = wdata; dmaIf.func3 = f3; dmaIf.req = 1'b1;
        end else begin
            cpuQ.push_back(e);
            cpuIf.we = we; cpuIf.addr = addr; cpuIf.wdata = wdata; cpuIf.func3 = f3; cpuIf.req = 1'b1;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            g = own ? dmaIf.gnt : cpuIf.gnt;
            if (g) break;
            waited++;
            if (waited > 50) begin
                checkOutput("gntTimeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (own) dmaIf.req = 1'b0;
        else     cpuIf.req = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        int wc;
        bit expOrder [10];
        sbEntry_t e;

        cpuIf.req = 0; cpuIf.we = 0; cpuIf.addr = 0; cpuIf.wdata = 0; cpuIf.func3 = 0;
        dmaIf.req = 0; dmaIf.we = 0; dmaIf.addr = 0; dmaIf.wdata = 0; dmaIf.func3 = 0;
        rst = 1'b1;
        idleCycles(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstGntDone", {60'd0, cpuIf.gnt, dmaIf.gnt, cpuIf.done, dmaIf.done}, 64'd0);
        checkOutput("rstErrWeRe", {60'd0, cpuIf.err, dmaIf.err, mem_we, mem_re}, 64'd0);
        checkOutput("rstMemAddr", mem_addr, 64'd0);
        checkOutput("rstMemWdata", mem_wdata, 64'd0);
        checkOutput("rstMemFunc3", 64'(mem_func3), 64'd0);
        checkOutput("rstRdata", cpuIf.rdata | dmaIf.rdata, 64'd0);
        @(posedge clk);
        #1;

        applyStimulus(0, 1, 64'h10, 64'h1122334455667788, F3_D, 0, 64'd0, w);
        applyStimulus(0, 0, 64'h10, 64'd0, F3_D, 0, 64'h1122334455667788, w);
        checkOutput("ldAfterSdWait", 64'(w), 64'd1);
        applyStimulus(0, 1, 64'h24, 64'h00000000DEADBEEF, F3_W, 0, 64'd0, w);
        applyStimulus(0, 0, 64'h24, 64'd0, F3_WU, 0, 64'h00000000DEADBEEF, w);
        checkOutput("lwuAfterSwWait", 64'(w), 64'd1);
        applyStimulus(0, 0, 64'h27, 64'd0, F3_B, 0, 64'hFFFFFFFFFFFFFFDE, w);
        applyStimulus(0, 0, 64'h3, 64'd0, F3_H, 1, 64'd0, w);
        applyStimulus(0, 1, 64'h10, 64'hBADBADBADBADBAD0, F3_BU, 1, 64'd0, w);
        applyStimulus(0, 0, 64'h10, 64'd0, F3_D, 0, 64'h1122334455667788, w);
        applyStimulus(0, 0, 64'h10, 64'd0, 3'b111, 1, 64'd0, w);
        applyStimulus(1, 0, 64'h24, 64'd0, F3_W, 0, 64'hFFFFFFFFDEADBEEF, w);
        applyStimulus(1, 1, 64'h12, 64'h5555555555555555, F3_D, 1, 64'd0, w);
        applyStimulus(1, 0, 64'h10, 64'd0, F3_D, 0, 64'h1122334455667788, w);
        idleCycles(3);

        logGrants = 1;
        fork
            begin
                int wCpu;
                for (int i = 0; i < 8; i++)
                    applyStimulus(0, 0, 64'h10, 64'd0, F3_D, 0, 64'h1122334455667788, wCpu);
            end
            begin
                int wDma;
                for (int i = 0; i < 2; i++)
                    applyStimulus(1, 0, 64'h24, 64'd0, F3_WU, 0, 64'h00000000DEADBEEF, wDma);
            end
        join
        idleCycles(3);
        logGrants = 0;
        expOrder = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        checkOutput("starveGntCount", 64'(gntLog.size()), 64'd10);
        for (int i = 0; i < 10 && i < gntLog.size(); i++) begin
            checkOutput($sformatf("starveOrder%0d", i), 64'(gntLog[i]), 64'(expOrder[i]));
            if (i > 0)
                checkOutput($sformatf("starveSpacing%0d", i), 64'(gntCycle[i] - gntCycle[i-1]), 64'd2);
        end

        dmaIf.we = 0; dmaIf.addr = 64'h10; dmaIf.func3 = F3_D; dmaIf.req = 1'b1;
        @(negedge clk);
        checkOutput("abortDmaGnt", 64'(dmaIf.gnt), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmaIf.req = 1'b0;
        @(negedge clk);
        checkOutput("abortNoDone", 64'(dmaIf.done), 64'd0);
        checkOutput("abortNoRe", 64'(mem_re), 64'd0);
        checkOutput("abortMemAddr", mem_addr, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e.we = 0; e.addr = 64'h10; e.err = 0; e.rdata = 64'h1122334455667788;
        cpuQ.push_back(e);
        cpuIf.we = 0; cpuIf.addr = 64'h10; cpuIf.wdata = 64'd0; cpuIf.func3 = F3_D; cpuIf.req = 1'b1;
        @(negedge clk);
        checkOutput("postRstCpuGnt", {62'd0, cpuIf.gnt, dmaIf.gnt}, 64'd2);
        checkOutput("postRstDoneErr", {60'd0, cpuIf.done, dmaIf.done, cpuIf.err, dmaIf.err}, 64'd0);
        checkOutput("postRstRdata", cpuIf.rdata | dmaIf.rdata, 64'd0);
        @(posedge clk);
        #1;
        cpuIf.req = 1'b0;
        wc = 0;
        while (cpuQ.size() > 0 && wc < 20) begin
            idleCycles(1);
            wc++;
        end
        idleCycles(3);

        checkOutput("cpuQueueEmpty", 64'(cpuQ.size()), 64'd0);
        checkOutput("dmaQueueEmpty", 64'(dmaQ.size()), 64'd0);
        checkOutput("neverBothGnt", 64'(bothGnt), 64'd0);
        checkOutput("neverBothDone", 64'(bothDone), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
